// File: rtl/hilo_pkg.sv
// Shared op codes, FSM states and counter sizing for the HI/LO register unit.
package hilo_pkg;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_MULT = 3'd1,
        OP_DIV  = 3'd2,
        OP_MTHI = 3'd3,
        OP_MTLO = 3'd4,
        OP_MFHI = 3'd5,
        OP_MFLO = 3'd6
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int MUL_LAT_DEF = 4;
    localparam int DIV_LAT_DEF = 32;

    // Counter must hold the larger of the two latencies.
    function automatic int cnt_width(input int mul_lat, input int div_lat);
        return $clog2(((mul_lat > div_lat) ? mul_lat : div_lat) + 1);
    endfunction

endpackage

// File: rtl/hilo_timer.sv
// Loadable down-counter that models MULT/DIV latency; owns the IDLE/RUN state.
module hilo_timer
    import hilo_pkg::*;
#(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             kill,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (kill && state_q == ST_RUN) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (load) begin
            state_d = ST_RUN;
            cnt_d   = load_val;
        end else if (state_q == ST_RUN) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = ST_IDLE;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_RUN) && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/hilo_unit.sv
// HI/LO register unit: captures ALU MULT/DIV results after a modelled latency,
// serves MTHI/MTLO/MFHI/MFLO and stalls EX on HI/LO hazards.
module hilo_unit
    import hilo_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [2:0]  op,
    input  logic [31:0] alu_lo,
    input  logic [31:0] alu_hi,
    input  logic [31:0] rs_data,
    input  logic        kill,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        busy,
    output logic        stall
);

    localparam int CNT_W = cnt_width(MUL_LAT, DIV_LAT);

    logic [31:0]      hi, lo, pend_hi, pend_lo;
    logic             accept, is_muldiv, load, done, commit;
    logic [CNT_W-1:0] load_val;

    assign accept    = req && !busy && !kill;
    assign stall     = req && busy && !kill;
    assign is_muldiv = (op == OP_MULT) || (op == OP_DIV);
    assign load      = accept && is_muldiv;
    assign load_val  = (op == OP_MULT) ? CNT_W'(MUL_LAT) : CNT_W'(DIV_LAT);
    // A kill on the final busy cycle still discards the pending result.
    assign commit    = done && !kill;

    hilo_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .kill     (kill),
        .busy     (busy),
        .done     (done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_hi <= '0;
            pend_lo <= '0;
        end else if (load) begin
            pend_hi <= alu_hi;
            pend_lo <= alu_lo;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (commit) begin
            hi <= pend_hi;
            lo <= pend_lo;
        end else if (accept) begin
            if (op == OP_MTHI) hi <= rs_data;
            if (op == OP_MTLO) lo <= rs_data;
        end
    end

    always_comb begin
        rd_data  = '0;
        rd_valid = 1'b0;
        if (accept && op == OP_MFHI) begin
            rd_data  = hi;
            rd_valid = 1'b1;
        end else if (accept && op == OP_MFLO) begin
            rd_data  = lo;
            rd_valid = 1'b1;
        end
    end

endmodule

// File: tb/tb_hilo_unit.sv
// Self-checking bench for hilo_unit: vector table plus multi-cycle sequences,
// read data checked through a scoreboard queue.
module tb_hilo_unit;
    import hilo_pkg::*;

    logic        clk = 1'b0;
    logic        rst, req, kill;
    logic [2:0]  op;
    logic [31:0] alu_lo, alu_hi, rs_data;
    logic [31:0] rd_data;
    logic        rd_valid, busy, stall;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic        req;
        logic [2:0]  op;
        logic [31:0] rs;
        logic        kill;
        logic        rv;
        logic [31:0] rd;
    } vec_t;
    vec_t tbl[11];

    hilo_unit #(.MUL_LAT(4), .DIV_LAT(32)) dut (
        .clk(clk), .rst(rst), .req(req), .op(op), .alu_lo(alu_lo), .alu_hi(alu_hi),
        .rs_data(rs_data), .kill(kill), .rd_data(rd_data), .rd_valid(rd_valid),
        .busy(busy), .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // One cycle: drive at posedge+1, sample at posedge+4, then advance.
    task automatic step(input string name, input logic r, input logic [2:0] o,
                        input logic [31:0] lo_v, input logic [31:0] hi_v,
                        input logic [31:0] rs, input logic k,
                        input logic e_stall, input logic e_busy,
                        input logic e_rv, input logic [31:0] e_rd);
        logic [31:0] want;
        req = r; op = o; alu_lo = lo_v; alu_hi = hi_v; rs_data = rs; kill = k;
        if (e_rv) exp_q.push_back(e_rd);
        #3;
        chk({name, ".stall"}, 32'(stall), 32'(e_stall));
        chk({name, ".busy"}, 32'(busy), 32'(e_busy));
        chk({name, ".rd_valid"}, 32'(rd_valid), 32'(e_rv));
        if (rd_valid) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL %s.rd_data: got %h want none", name, rd_data);
            end else begin
                want = exp_q.pop_front();
                chk({name, ".rd_data"}, rd_data, want);
            end
        end else begin
            chk({name, ".rd_zero"}, rd_data, 32'h0);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input string name, input logic e_busy);
        step(name, 1'b0, OP_NONE, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, e_busy, 1'b0, 32'h0);
    endtask

    initial begin
        tbl[0]  = '{1'b1, OP_MFHI, 32'h0,        1'b0, 1'b1, 32'h0};
        tbl[1]  = '{1'b1, OP_MFLO, 32'h0,        1'b0, 1'b1, 32'h0};
        tbl[2]  = '{1'b1, OP_MTHI, 32'h12345678, 1'b0, 1'b0, 32'h0};
        tbl[3]  = '{1'b1, OP_MFHI, 32'h0,        1'b0, 1'b1, 32'h12345678};
        tbl[4]  = '{1'b1, OP_MTLO, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0};
        tbl[5]  = '{1'b1, OP_MFLO, 32'h0,        1'b0, 1'b1, 32'hA5A5A5A5};
        tbl[6]  = '{1'b1, 3'd7,    32'hFFFFFFFF, 1'b0, 1'b0, 32'h0};
        tbl[7]  = '{1'b1, OP_NONE, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0};
        tbl[8]  = '{1'b1, OP_MTHI, 32'h0BADF00D, 1'b1, 1'b0, 32'h0};
        tbl[9]  = '{1'b1, OP_MFHI, 32'h0,        1'b0, 1'b1, 32'h12345678};
        tbl[10] = '{1'b1, OP_MFHI, 32'h0,        1'b1, 1'b0, 32'h0};

        rst = 1'b1; req = 1'b0; op = OP_NONE; kill = 1'b0;
        alu_lo = '0; alu_hi = '0; rs_data = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        idle("reset", 1'b0);

        for (int i = 0; i < 11; i++)
            step($sformatf("vec%0d", i), tbl[i].req, tbl[i].op, 32'h0, 32'h0, tbl[i].rs,
                 tbl[i].kill, 1'b0, 1'b0, tbl[i].rv, tbl[i].rd);

        // MULT, then MFLO stalled through the latency window
        step("mult", 1'b1, OP_MULT, 32'h80000000, 32'h00000001, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int c = 1; c <= 4; c++)
            step($sformatf("mflo_stall%0d", c), 1'b1, OP_MFLO, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        step("mflo_post", 1'b1, OP_MFLO, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h80000000);
        step("mfhi_post", 1'b1, OP_MFHI, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00000001);

        // back-to-back MULT: second accepted in cycle LAT+1 with that cycle's ALU values
        step("mult_a", 1'b1, OP_MULT, 32'h3, 32'h2, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int c = 1; c <= 4; c++)
            step($sformatf("mult_b_stall%0d", c), 1'b1, OP_MULT, 32'h9, 32'h9, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        step("mult_b", 1'b1, OP_MULT, 32'h5, 32'h4, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int c = 1; c <= 4; c++) idle($sformatf("mult_b_busy%0d", c), 1'b1);
        step("b2b_lo", 1'b1, OP_MFLO, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h5);
        step("b2b_hi", 1'b1, OP_MFHI, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h4);

        // divide by zero results committed verbatim after DIV_LAT
        step("div0", 1'b1, OP_DIV, 32'hFFFFFFFF, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int c = 1; c <= 32; c++)
            step($sformatf("div_stall%0d", c), 1'b1, OP_MFHI, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        step("div_hi", 1'b1, OP_MFHI, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
        step("div_lo", 1'b1, OP_MFLO, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF);

        // MTLO while busy waits for commit, then overwrites lo
        step("mult_c", 1'b1, OP_MULT, 32'h22, 32'h11, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int c = 1; c <= 4; c++)
            step($sformatf("mtlo_stall%0d", c), 1'b1, OP_MTLO, 32'h0, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        step("mtlo_acc", 1'b1, OP_MTLO, 32'h0, 32'h0, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step("mtlo_lo", 1'b1, OP_MFLO, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hCAFEF00D);
        step("mtlo_hi", 1'b1, OP_MFHI, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h11);

        // kill in cycle 2 aborts the MULT; MTHI alongside kill is dropped
        step("mult_k", 1'b1, OP_MULT, 32'h88, 32'h77, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        idle("kill_c1", 1'b1);
        step("kill_c2", 1'b1, OP_MTHI, 32'h0, 32'h0, 32'h99, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        step("kill_hi", 1'b1, OP_MFHI, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h11);
        step("kill_lo", 1'b1, OP_MFLO, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hCAFEF00D);
        for (int c = 0; c < 6; c++) idle($sformatf("kill_nocommit%0d", c), 1'b0);
        step("kill_hi2", 1'b1, OP_MFHI, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h11);

        // rst in cycle 3 of a DIV clears everything; no late commit
        step("div_r", 1'b1, OP_DIV, 32'hBBBB, 32'hAAAA, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        idle("div_r1", 1'b1);
        idle("div_r2", 1'b1);
        rst = 1'b1; req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        idle("rst_after", 1'b0);
        step("rst_hi", 1'b1, OP_MFHI, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        step("rst_lo", 1'b1, OP_MFLO, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        for (int c = 0; c < 34; c++) idle($sformatf("rst_idle%0d", c), 1'b0);
        step("rst_hi2", 1'b1, OP_MFHI, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        step("rst_lo2", 1'b1, OP_MFLO, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
